// File: rtl/batch_sample_mem_if.sv
// Sample-memory bus between the batch filter (master) and the sample store (slave).
// One write port plus three read ports; ready qualifies everything after a clear sweep.
interface batch_sample_mem_if #(
   parameter int unsigned WIDTH  = 48,
   parameter int unsigned ADDR_W = 7
);
   // No per-transfer handshake: the master may present a write and three read
   // addresses every clkDS cycle, and they are honoured only while ready is high.
   // Read data always follows its address by exactly one edge.
   logic              clr;
   logic              sampleWrite;
   logic [ADDR_W-1:0] sampleAddrIn;
   logic [WIDTH-1:0]  sampleDataIn;
   logic [ADDR_W-1:0] sampleAddrOut1;
   logic [ADDR_W-1:0] sampleAddrOut2;
   logic [ADDR_W-1:0] sampleAddrOut3;
   logic [WIDTH-1:0]  sampleDataOut1;
   logic [WIDTH-1:0]  sampleDataOut2;
   logic [WIDTH-1:0]  sampleDataOut3;
   logic              ready;
   logic              oobErr;

   modport master (
      output clr, sampleWrite, sampleAddrIn, sampleDataIn,
      output sampleAddrOut1, sampleAddrOut2, sampleAddrOut3,
      input  sampleDataOut1, sampleDataOut2, sampleDataOut3, ready, oobErr
   );

   modport slave (
      input  clr, sampleWrite, sampleAddrIn, sampleDataIn,
      input  sampleAddrOut1, sampleAddrOut2, sampleAddrOut3,
      output sampleDataOut1, sampleDataOut2, sampleDataOut3, ready, oobErr
   );
endinterface

// File: rtl/batch_sample_mem.sv
// Sample store with one write and three registered read ports, a zeroing sweep
// after reset or clr, write-first bypass and a sticky out-of-range flag.
module batch_sample_mem #(
   parameter int unsigned WIDTH       = 48,
   parameter int unsigned DEPTH_WORDS = 76,
   parameter int unsigned ADDR_W      = 7
) (
   input  logic              clkDS,
   input  logic              rst,
   batch_sample_mem_if.slave bus,
   output logic              dbg_state_o
);
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              ready_q;
   logic              oob_q;
   logic [WIDTH-1:0]  dout_q [3];
   logic [WIDTH-1:0]  dout_d [3];

   logic [WIDTH-1:0]  mem_q [DEPTH_WORDS];

   logic [ADDR_W-1:0] rd_addr [3];
   logic [2:0]        rd_ok;
   logic              wr_ok;
   logic              run_wr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [WIDTH-1:0]  mem_wd;
   logic              oob_hit;

   assign rd_addr[0] = bus.sampleAddrOut1;
   assign rd_addr[1] = bus.sampleAddrOut2;
   assign rd_addr[2] = bus.sampleAddrOut3;

   always_comb begin
      wr_ok   = 32'(bus.sampleAddrIn) < DEPTH_WORDS;
      run_wr  = (state_q == RUN) && bus.sampleWrite && wr_ok;
      // The sweep owns the single write port while clearing.
      mem_we  = (state_q == CLEAR) || run_wr;
      mem_wa  = (state_q == CLEAR) ? ptr_q : bus.sampleAddrIn;
      mem_wd  = (state_q == CLEAR) ? '0 : bus.sampleDataIn;
      rd_ok   = '0;
      for (int p = 0; p < 3; p++) begin
         rd_ok[p]  = 32'(rd_addr[p]) < DEPTH_WORDS;
         dout_d[p] = '0;
         if (state_q == RUN && rd_ok[p]) begin
            if (run_wr && rd_addr[p] == bus.sampleAddrIn) begin
               dout_d[p] = bus.sampleDataIn;
            end else begin
               dout_d[p] = mem_q[rd_addr[p]];
            end
         end
      end
      oob_hit = (state_q == RUN) && ((bus.sampleWrite && !wr_ok) || (rd_ok != 3'b111));
   end

   // Storage has no reset so it can map onto block RAM; the sweep zeroes it.
   always_ff @(posedge clkDS) begin
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   always_ff @(posedge clkDS or negedge rst) begin
      if (!rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         ready_q <= 1'b0;
         oob_q   <= 1'b0;
         for (int p = 0; p < 3; p++) begin
            dout_q[p] <= '0;
         end
      end else begin
         dout_q <= dout_d;
         if (oob_hit) begin
            oob_q <= 1'b1;
         end
         case (state_q)
            CLEAR: begin
               if (bus.clr) begin
                  ptr_q <= '0;
               end else if (ptr_q == LAST_ADDR) begin
                  ptr_q   <= '0;
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            RUN: begin
               if (bus.clr) begin
                  ptr_q   <= '0;
                  state_q <= CLEAR;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= CLEAR;
               ptr_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sampleDataOut1 = dout_q[0];
   assign bus.sampleDataOut2 = dout_q[1];
   assign bus.sampleDataOut3 = dout_q[2];
   assign bus.ready          = ready_q;
   assign bus.oobErr         = oob_q;
   assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_batch_sample_mem.sv
// Scenario bench for batch_sample_mem: sweep timing, read/write, bypass,
// out-of-range flag, clr, random traffic against a model, and async reset.
module tb_batch_sample_mem;
   localparam int W     = 48;
   localparam int AW    = 7;
   localparam int DEPTH = 76;

   logic          clkDS;
   logic          rst;
   logic          dbg_state;
   logic [W-1:0]  dout [3];
   logic [W-1:0]  exp_q [$];
   logic [W-1:0]  ref_mem [DEPTH];
   logic [W-1:0]  exp_v;
   int            n_checks;
   int            n_pass;

   batch_sample_mem_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

   batch_sample_mem #(.WIDTH(W), .DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
      .clkDS       (clkDS),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   assign dout[0] = bus.sampleDataOut1;
   assign dout[1] = bus.sampleDataOut2;
   assign dout[2] = bus.sampleDataOut3;

   // clock / reset
   initial clkDS = 1'b0;
   always #5 clkDS = ~clkDS;

   // driver tasks
   task automatic step();
      @(posedge clkDS);
      #1;
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] a3, input logic c);
      bus.sampleWrite    = we;
      bus.sampleAddrIn   = wa;
      bus.sampleDataIn   = wd;
      bus.sampleAddrOut1 = a1;
      bus.sampleAddrOut2 = a2;
      bus.sampleAddrOut3 = a3;
      bus.clr            = c;
   endtask

   task automatic test_reset();
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
      rst = 1'b0;
      step();
      step();
      n_checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready); else n_pass++;
      n_checks++; if (bus.oobErr !== 1'b0) $display("FAIL reset_oob got %b want 0", bus.oobErr); else n_pass++;
      n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state got %b want 0", dbg_state); else n_pass++;
      for (int p = 0; p < 3; p++) begin
         n_checks++;
         if (dout[p] !== '0) $display("FAIL reset_dout port%0d got %h want 0", p + 1, dout[p]);
         else n_pass++;
      end
   endtask

   task automatic test_sweep();
      int n;
      logic dirty;
      n = 0;
      dirty = 1'b0;
      drive(1'b1, 7'd5, 48'hAAA, 7'd5, 7'd5, 7'd5, 1'b0);
      rst = 1'b1;
      while (bus.ready !== 1'b1 && n < 200) begin
         step();
         n++;
         if (dout[0] !== '0 || dout[1] !== '0 || dout[2] !== '0) dirty = 1'b1;
      end
      n_checks++; if (n !== DEPTH) $display("FAIL sweep_edges got %0d want %0d", n, DEPTH); else n_pass++;
      n_checks++; if (dirty !== 1'b0) $display("FAIL sweep_dout_zero got %b want 0", dirty); else n_pass++;
      drive(1'b0, 7'd5, '0, 7'd5, 7'd5, 7'd5, 1'b0);
      for (int p = 0; p < 3; p++) exp_q.push_back('0);
      step();
      for (int p = 0; p < 3; p++) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (dout[p] !== exp_v) $display("FAIL sweep_first_read port%0d got %h want %h", p + 1, dout[p], exp_v);
         else n_pass++;
      end
      n_checks++; if (bus.oobErr !== 1'b0) $display("FAIL sweep_oob got %b want 0", bus.oobErr); else n_pass++;
   endtask

   task automatic test_write_read();
      drive(1'b1, 7'd10, 48'h123456789ABC, 7'd0, 7'd1, 7'd2, 1'b0);
      step();
      drive(1'b0, '0, '0, 7'd10, 7'd10, 7'd10, 1'b0);
      for (int p = 0; p < 3; p++) exp_q.push_back(48'h123456789ABC);
      step();
      for (int p = 0; p < 3; p++) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (dout[p] !== exp_v) $display("FAIL write_read port%0d got %h want %h", p + 1, dout[p], exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_bypass();
      drive(1'b1, 7'd20, 48'h5, 7'd0, 7'd0, 7'd0, 1'b0);
      step();
      drive(1'b1, 7'd20, 48'hFFFF00001111, 7'd21, 7'd20, 7'd20, 1'b0);
      exp_q.push_back('0);
      exp_q.push_back(48'hFFFF00001111);
      exp_q.push_back(48'hFFFF00001111);
      step();
      drive(1'b0, '0, '0, 7'd20, 7'd21, 7'd20, 1'b0);
      exp_q.push_back(48'hFFFF00001111);
      exp_q.push_back('0);
      exp_q.push_back(48'hFFFF00001111);
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < 3; p++) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dout[p] !== exp_v) $display("FAIL bypass_c%0d port%0d got %h want %h", c, p + 1, dout[p], exp_v);
            else n_pass++;
         end
         if (c == 0) step();
      end
   endtask

   task automatic test_oob();
      n_checks++; if (bus.oobErr !== 1'b0) $display("FAIL oob_before got %b want 0", bus.oobErr); else n_pass++;
      drive(1'b1, 7'd80, 48'h7, 7'd10, 7'd20, 7'd0, 1'b0);
      exp_q.push_back(48'h123456789ABC);
      exp_q.push_back(48'hFFFF00001111);
      exp_q.push_back('0);
      step();
      n_checks++; if (bus.oobErr !== 1'b1) $display("FAIL oob_write got %b want 1", bus.oobErr); else n_pass++;
      drive(1'b0, '0, '0, 7'd10, 7'd20, 7'd90, 1'b0);
      exp_q.push_back(48'h123456789ABC);
      exp_q.push_back(48'hFFFF00001111);
      exp_q.push_back('0);
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < 3; p++) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dout[p] !== exp_v) $display("FAIL oob_c%0d port%0d got %h want %h", c, p + 1, dout[p], exp_v);
            else n_pass++;
         end
         if (c == 0) step();
      end
      n_checks++; if (bus.oobErr !== 1'b1) $display("FAIL oob_sticky got %b want 1", bus.oobErr); else n_pass++;
   endtask

   task automatic test_clr();
      int n;
      drive(1'b1, 7'd3, 48'h9, 7'd3, 7'd3, 7'd3, 1'b1);
      for (int p = 0; p < 3; p++) exp_q.push_back(48'h9);
      step();
      for (int p = 0; p < 3; p++) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (dout[p] !== exp_v) $display("FAIL clr_cycle_read port%0d got %h want %h", p + 1, dout[p], exp_v);
         else n_pass++;
      end
      n_checks++; if (bus.ready !== 1'b0) $display("FAIL clr_ready_drop got %b want 0", bus.ready); else n_pass++;
      drive(1'b0, '0, '0, 7'd3, 7'd10, 7'd20, 1'b0);
      n = 0;
      while (bus.ready !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      n_checks++; if (n !== DEPTH) $display("FAIL clr_sweep_edges got %0d want %0d", n, DEPTH); else n_pass++;
      n_checks++; if (bus.oobErr !== 1'b1) $display("FAIL clr_oob_kept got %b want 1", bus.oobErr); else n_pass++;
      for (int p = 0; p < 3; p++) exp_q.push_back('0);
      step();
      for (int p = 0; p < 3; p++) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (dout[p] !== exp_v) $display("FAIL clr_cleared port%0d got %h want %h", p + 1, dout[p], exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic          we;
      logic [AW-1:0] wa;
      logic [W-1:0]  wd;
      logic [AW-1:0] ra [3];
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      for (int i = 0; i < 200; i++) begin
         we = 1'($urandom_range(0, 1));
         wa = AW'($urandom_range(0, DEPTH - 1));
         wd = {16'($urandom), 32'($urandom)};
         for (int p = 0; p < 3; p++) begin
            ra[p] = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            exp_q.push_back((we && ra[p] == wa) ? wd : ref_mem[ra[p]]);
         end
         drive(we, wa, wd, ra[0], ra[1], ra[2], 1'b0);
         step();
         if (we) ref_mem[wa] = wd;
         for (int p = 0; p < 3; p++) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (dout[p] !== exp_v) $display("FAIL random_i%0d port%0d got %h want %h", i, p + 1, dout[p], exp_v);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      drive(1'b1, 7'd7, 48'h55, 7'd7, 7'd7, 7'd7, 1'b0);
      step();
      drive(1'b0, '0, '0, 7'd0, 7'd0, 7'd0, 1'b0);
      #2 rst = 1'b0;
      #1;
      n_checks++; if (dout[0] !== '0) $display("FAIL run_reset_dout got %h want 0", dout[0]); else n_pass++;
      n_checks++; if (bus.ready !== 1'b0) $display("FAIL run_reset_ready got %b want 0", bus.ready); else n_pass++;
      n_checks++; if (bus.oobErr !== 1'b0) $display("FAIL run_reset_oob got %b want 0", bus.oobErr); else n_pass++;
      #2 rst = 1'b1;
      for (int i = 0; i < 30; i++) step();
      #2 rst = 1'b0;
      #1;
      n_checks++; if (bus.ready !== 1'b0) $display("FAIL sweep_reset_ready got %b want 0", bus.ready); else n_pass++;
      n_checks++; if (dbg_state !== 1'b0) $display("FAIL sweep_reset_state got %b want 0", dbg_state); else n_pass++;
      #2 rst = 1'b1;
      n = 0;
      while (bus.ready !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      n_checks++; if (n !== DEPTH) $display("FAIL sweep_reset_edges got %0d want %0d", n, DEPTH); else n_pass++;
      drive(1'b0, '0, '0, 7'd7, 7'd10, 7'd3, 1'b0);
      for (int p = 0; p < 3; p++) exp_q.push_back('0);
      step();
      for (int p = 0; p < 3; p++) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (dout[p] !== exp_v) $display("FAIL sweep_reset_read port%0d got %h want %h", p + 1, dout[p], exp_v);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b0;
      test_reset();
      test_sweep();
      test_write_read();
      test_bypass();
      test_oob();
      test_clr();
      test_random();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
